cds_readout: RTL and testbench
==============================

CDS_READOUT -- requirements
Module: cds_readout

Interface
REQ-001 Parameter resolution, default 8, bit width of ADC samples and pixel result.
REQ-002 Parameter settle_cycles, default 4, wait cycles after each sample_sel change before a conversion is started.
REQ-003 Parameter timeout_cycles, default 64, maximum cycles allowed from sar_enable pulse to adc_done rising edge.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one correlated-double-sample readout; sampled only in IDLE.
REQ-007 adc_done  input  1  SAR completion level; a conversion completes on its 0->1 transition.
REQ-008 adc_value  input  resolution  SAR result; valid when adc_done is high.
REQ-009 sar_enable  output  1  one-cycle pulse that launches a SAR conversion.
REQ-010 sample_sel  output  1  pixel mux select: 0 = reset level, 1 = signal level.
REQ-011 pixel_out  output  resolution  CDS result.
REQ-012 pixel_valid  output  1  pixel_out holds an unconsumed result.
REQ-013 pixel_ready  input  1  downstream accepts pixel_out when pixel_valid and pixel_ready are both high on a posedge.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  sticky error flag.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE_RST, CONV_RST, SETTLE_SIG, CONV_SIG, CALC, HOLD.
REQ-017 IDLE with start=1 SHALL go to SETTLE_RST with sample_sel=0 and the settle counter cleared.
REQ-018 SETTLE_x SHALL count settle_cycles cycles, then pulse sar_enable high for exactly one cycle and enter CONV_x.
REQ-019 adc_done SHALL be registered once and its rising edge detected; a level already high on entry to CONV_x SHALL NOT count as completion.
REQ-020 CONV_RST on adc_done rising edge SHALL capture adc_value into rst_sample, set sample_sel=1, and go to SETTLE_SIG.
REQ-021 CONV_SIG on adc_done rising edge SHALL capture adc_value into sig_sample and go to CALC.
REQ-022 CALC SHALL compute rst_sample - sig_sample at resolution+1 bits and clamp negative results to 0.
REQ-023 CALC SHALL load the clamped result into pixel_out when pixel_valid=0, or when pixel_valid=1 and pixel_ready=1 in the same cycle, then return to IDLE; otherwise it SHALL go to HOLD.
REQ-024 HOLD SHALL keep the result and load it under the same condition as REQ-023, then go to IDLE.
REQ-025 When pixel_valid=1 and pixel_ready=1 with no new load, pixel_valid SHALL clear on the next posedge; pixel_out SHALL stay stable while pixel_valid=1 and unaccepted.
REQ-026 Latency from start to pixel_valid with an idle output and a SAR taking C cycles SHALL be 2*(settle_cycles+1+C)+3 cycles, plus or minus 1 for edge-detect registration, fixed per implementation and documented in the testbench.
REQ-027 Each CONV_x SHALL count cycles from the sar_enable pulse; on reaching timeout_cycles without a completion edge it SHALL set timeout_err=1, set sample_sel=0, discard samples, produce no pixel, and return to IDLE.
REQ-028 timeout_err SHALL clear only on reset or on the next accepted start.
REQ-029 start asserted outside IDLE SHALL be ignored, with no queueing.
REQ-030 sample_sel SHALL return to 0 on entering IDLE.

Reset
REQ-031 Asserting reset at any time, including mid-conversion, SHALL immediately force state=IDLE, sar_enable=0, sample_sel=0, pixel_out=0, pixel_valid=0, busy=0, timeout_err=0, and clear all counters and captured samples.
REQ-032 The first start after reset deassertion SHALL be honoured only on a posedge where reset is low.

Verification
REQ-033 Nominal: SAR model returns 200 then 50, pixel_ready=1 -> pixel_out=150, pixel_valid high one cycle, exactly two sar_enable pulses.
REQ-034 Clamp: SAR returns 40 then 90 -> pixel_out=0, pixel_valid=1.
REQ-035 Backpressure: pixel_ready=0, two readouts (200/50, then 100/30) -> first result 150 held stable, FSM in HOLD, busy=1; raising pixel_ready for one cycle accepts 150, then loads 70.
REQ-036 Timeout: SAR never raises adc_done -> timeout_err=1 after timeout_cycles, busy=0, pixel_valid stays 0; next start clears timeout_err.
REQ-037 Stale done: adc_done held high before start -> no capture until adc_done falls and rises again.
REQ-038 Reset mid-operation: reset asserted during CONV_SIG -> all outputs at reset values in the same cycle and no pixel is emitted afterwards.

Source files
------------

// File: rtl/cds_readout.sv
// rtl/cds_readout.sv - correlated double sampling readout sequencer
// Samples the reset level then the signal level through a SAR ADC and emits the clamped difference.
module cds_readout #(
  parameter int resolution     = 8,
  parameter int settle_cycles  = 4,
  parameter int timeout_cycles = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  adc_done,
  input  logic [resolution-1:0] adc_value,
  output logic                  sar_enable,
  output logic                  sample_sel,
  output logic [resolution-1:0] pixel_out,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int sw = (settle_cycles > 1) ? $clog2(settle_cycles + 1) : 1;
  localparam int tw = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [sw-1:0] settle_last = sw'(settle_cycles - 1);
  localparam logic [tw-1:0] timeout_last = tw'(timeout_cycles - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE_RST, CONV_RST, SETTLE_SIG, CONV_SIG, CALC, HOLD
  } state_t;

  state_t                state;
  logic [sw-1:0]         settle_cnt;
  logic [tw-1:0]         conv_cnt;
  logic                  done_q;
  logic                  done_qq;
  logic [resolution-1:0] rst_sample;
  logic [resolution-1:0] sig_sample;

  logic                  done_rise;
  logic [resolution:0]   diff;
  logic [resolution-1:0] clamped;
  logic                  can_load;

  // Edge is taken on the registered level so a level already high on entry never counts.
  assign done_rise = done_q & ~done_qq;
  assign diff      = {1'b0, rst_sample} - {1'b0, sig_sample};
  assign clamped   = diff[resolution] ? '0 : diff[resolution-1:0];
  assign can_load  = !pixel_valid || pixel_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      conv_cnt    <= '0;
      done_q      <= 1'b0;
      done_qq     <= 1'b0;
      rst_sample  <= '0;
      sig_sample  <= '0;
      sar_enable  <= 1'b0;
      sample_sel  <= 1'b0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done_q     <= adc_done;
      done_qq    <= done_q;
      sar_enable <= 1'b0;
      if (pixel_valid && pixel_ready) pixel_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= SETTLE_RST;
            sample_sel  <= 1'b0;
            settle_cnt  <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
          end
        end

        SETTLE_RST, SETTLE_SIG: begin
          if (settle_cnt == settle_last) begin
            sar_enable <= 1'b1;
            conv_cnt   <= '0;
            state      <= (state == SETTLE_RST) ? CONV_RST : CONV_SIG;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        CONV_RST, CONV_SIG: begin
          if (done_rise) begin
            if (state == CONV_RST) begin
              rst_sample <= adc_value;
              sample_sel <= 1'b1;
              settle_cnt <= '0;
              state      <= SETTLE_SIG;
            end else begin
              sig_sample <= adc_value;
              state      <= CALC;
            end
          end else if (conv_cnt == timeout_last) begin
            // Abandon the readout entirely; a partial pair is meaningless.
            timeout_err <= 1'b1;
            sample_sel  <= 1'b0;
            rst_sample  <= '0;
            sig_sample  <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end

        CALC, HOLD: begin
          if (can_load) begin
            pixel_out   <= clamped;
            pixel_valid <= 1'b1;
            sample_sel  <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            state <= HOLD;
          end
        end

        default: begin
          sample_sel <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cds_readout.sv
// tb/tb_cds_readout.sv - directed self-checking bench for cds_readout
// Start-to-valid latency is 2*(settle_cycles+1+C)+3 with C counted in SAR model negedges.
module tb_cds_readout;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       adc_done = 1'b0;
  logic [7:0] adc_value = 8'd0;
  logic       sar_enable;
  logic       sample_sel;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       pixel_ready;
  logic       busy;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  int en_count = 0;

  // SAR model controls: mode 0 normal, 1 never completes, 2 manual level/value
  int         mode = 0;
  int         conv_c = 3;
  logic [7:0] rst_v = 8'd0;
  logic [7:0] sig_v = 8'd0;
  logic       man_done = 1'b0;
  logic [7:0] man_val = 8'd0;
  int         sar_cnt = 0;
  bit         pending = 1'b0;

  cds_readout #(.resolution(8), .settle_cycles(4), .timeout_cycles(64)) dut (
    .clk(clk), .reset(reset), .start(start), .adc_done(adc_done), .adc_value(adc_value),
    .sar_enable(sar_enable), .sample_sel(sample_sel), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sar_enable === 1'b1) en_count++;

  always @(negedge clk) begin
    if (mode == 2) begin
      adc_done  = man_done;
      adc_value = man_val;
    end else if (sar_enable === 1'b1) begin
      adc_done = 1'b0;
      sar_cnt  = conv_c;
      pending  = 1'b1;
    end else if (pending) begin
      sar_cnt--;
      if (sar_cnt == 0) begin
        pending = 1'b0;
        if (mode == 0) begin
          adc_done  = 1'b1;
          adc_value = sample_sel ? sig_v : rst_v;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (pixel_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int n;
  int e0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pixel_ready = 1'b1;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_sar_enable", sar_enable, 0);
    check("rst_sample_sel", sample_sel, 0);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    tick();

    // Nominal 200/50, latency 2*(4+1+3)+3 = 19
    rst_v = 8'd200; sig_v = 8'd50;
    e0 = en_count;
    do_start();
    check("nom_busy", busy, 1);
    wait_valid(200, n);
    check("nom_latency", n, 19);
    check("nom_pixel_out", pixel_out, 150);
    check("nom_idle", busy, 0);
    tick();
    check("nom_valid_one_cycle", pixel_valid, 0);
    check("nom_enable_pulses", en_count - e0, 2);

    // Clamp 40/90 with an ignored start mid-readout
    rst_v = 8'd40; sig_v = 8'd90;
    e0 = en_count;
    do_start();
    repeat (5) tick();
    do_start();
    wait_valid(200, n);
    check("clamp_pixel_out", pixel_out, 0);
    check("clamp_pixel_valid", pixel_valid, 1);
    repeat (30) tick();
    check("ignored_start_busy", busy, 0);
    check("ignored_start_pulses", en_count - e0, 2);

    // Full-scale difference
    rst_v = 8'd255; sig_v = 8'd0;
    do_start();
    wait_valid(200, n);
    check("full_scale", pixel_out, 255);
    tick();

    // Backpressure: 200/50 held, then 100/30 waits in HOLD
    pixel_ready = 1'b0;
    rst_v = 8'd200; sig_v = 8'd50;
    do_start();
    wait_valid(200, n);
    check("bp_first", pixel_out, 150);
    repeat (3) tick();
    check("bp_first_held_valid", pixel_valid, 1);
    rst_v = 8'd100; sig_v = 8'd30;
    do_start();
    repeat (19) tick();
    check("bp_hold_busy", busy, 1);
    check("bp_hold_out", pixel_out, 150);
    check("bp_hold_valid", pixel_valid, 1);
    do_start();
    pixel_ready = 1'b1;
    tick();
    pixel_ready = 1'b0;
    check("bp_second_out", pixel_out, 70);
    check("bp_second_valid", pixel_valid, 1);
    check("bp_second_idle", busy, 0);
    repeat (5) tick();
    check("bp_no_queued_start", busy, 0);
    check("bp_second_stable", pixel_out, 70);
    pixel_ready = 1'b1;
    tick();
    check("bp_accept_clears", pixel_valid, 0);

    // Timeout: pulse at posedge 4, error at posedge 4+64
    mode = 1;
    do_start();
    repeat (67) tick();
    check("to_before_err", timeout_err, 0);
    check("to_before_busy", busy, 1);
    tick();
    check("to_err", timeout_err, 1);
    check("to_busy", busy, 0);
    check("to_valid", pixel_valid, 0);
    check("to_sample_sel", sample_sel, 0);
    repeat (3) tick();
    check("to_sticky", timeout_err, 1);
    mode = 0;
    rst_v = 8'd120; sig_v = 8'd20;
    do_start();
    check("to_cleared_by_start", timeout_err, 0);
    wait_valid(200, n);
    check("to_recover_out", pixel_out, 100);
    tick();

    // Stale done: level high before start must not complete CONV_RST
    mode = 2;
    man_done = 1'b1; man_val = 8'd99;
    repeat (3) tick();
    do_start();
    repeat (12) tick();
    check("stale_no_capture", sample_sel, 0);
    check("stale_busy", busy, 1);
    man_done = 1'b0;
    repeat (2) tick();
    man_val = 8'd180; man_done = 1'b1;
    repeat (3) tick();
    check("stale_capture_after_edge", sample_sel, 1);
    man_done = 1'b0;
    repeat (8) tick();
    man_val = 8'd30; man_done = 1'b1;
    wait_valid(20, n);
    check("stale_pixel_out", pixel_out, 150);
    tick();
    mode = 0;

    // Reset during CONV_SIG (entered at posedge 13, capture due at 18)
    rst_v = 8'd200; sig_v = 8'd60;
    do_start();
    repeat (15) tick();
    check("mid_sample_sel_pre", sample_sel, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sar_enable", sar_enable, 0);
    check("mid_rst_sample_sel", sample_sel, 0);
    check("mid_rst_pixel_out", pixel_out, 0);
    check("mid_rst_pixel_valid", pixel_valid, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    start = 1'b1;
    repeat (2) tick();
    check("start_in_reset_ignored", busy, 0);
    start = 1'b0;
    reset = 1'b0;
    e0 = en_count;
    repeat (40) tick();
    check("post_rst_no_pixel", pixel_valid, 0);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_pulse", en_count - e0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
